mcl_host_req_gate: RTL and testbench

- Sits between the host AXI-Lite/MCL adapter and the manycore link endpoint.
- Host request path: host MCL packet -> gate -> manycore link. Response path: manycore -> gate -> host.
- Enforces two limits: manycore endpoint credits, and host receive-FIFO space reserved for load replies. This prevents reply loss and head-of-line deadlock. Drops illegal opcodes and reports them, and provides an idle/fence indication for host software.

---
 rtl/bsg_mcl_host_pkg.sv | 19 +
 rtl/mcl_pipe_reg.sv | 61 ++++++
 rtl/mcl_host_req_gate.sv | 199 +++++++++++++++++++
 tb/tb_mcl_host_req_gate.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mcl_host_pkg.sv
// Shared definitions for the host MCL request gate.
//   - mcl_op_e    : request opcodes carried in the top byte of every MCL packet
//   - McOpWidth   : width of the opcode field
//   - buf_state_e : occupancy state of a one-entry pipe register
package bsg_mcl_host_pkg;

  localparam int unsigned McOpWidth = 8;

  typedef enum logic [McOpWidth-1:0] {
    e_mcl_op_store = 8'h00,
    e_mcl_op_load  = 8'h01
  } mcl_op_e;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } buf_state_e;

endpackage

// File: rtl/mcl_pipe_reg.sv
// One-entry valid/ready pipe register.
// Accepts a new entry when empty, or when full and the current entry leaves in the
// same cycle, so back-to-back traffic flows at one item per cycle with one cycle of
// latency. The held data is stable while v_o is high and r_i is low.
//
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset (register empties)
//   v_i, data_i    : upstream valid / data
//   r_o            : upstream ready (empty, or draining this cycle)
//   v_o, data_o    : downstream valid / data
//   r_i            : downstream ready
module mcl_pipe_reg
  import bsg_mcl_host_pkg::*;
#(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               r_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               r_i
);

  buf_state_e         state_q;
  logic [width_p-1:0] data_q;

  assign r_o    = (state_q == StEmpty) | r_i;
  assign v_o    = (state_q == StFull);
  assign data_o = data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StEmpty;
      data_q  <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (v_i) begin
            state_q <= StFull;
            data_q  <= data_i;
          end
        end
        StFull: begin
          if (r_i) begin
            // Simultaneous drain and fill keeps the register full.
            if (v_i) begin
              data_q <= data_i;
            end else begin
              state_q <= StEmpty;
            end
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: rtl/mcl_host_req_gate.sv
// Host request gate between the host MCL adapter and the manycore link endpoint.
// Requests are only admitted when an endpoint credit is available and, for loads,
// when the adapter's receive FIFO has room reserved for the reply. Illegal opcodes
// are swallowed and counted. Replies pass through a one-entry pipe register.
//
// Ports:
//   clk_i, reset_i       : clock, asynchronous active-high reset
//   host_v_i/_data_i/_r_o: request from the adapter
//   rcv_vacancy_i        : free entries in the adapter receive FIFO
//   link_v_o/_data_o/_r_i: request to the manycore endpoint
//   link_credit_i        : one-cycle pulse, one endpoint credit returned
//   resp_v_i/_data_i/_r_o: load reply from the endpoint
//   host_resp_*          : load reply to the adapter
//   idle_o               : nothing outstanding anywhere (registered, lags by one cycle)
//   drop_count_o         : saturating count of dropped illegal-opcode packets
//   err_o                : sticky protocol error (spurious credit or reply)
module mcl_host_req_gate
  import bsg_mcl_host_pkg::*;
#(
  parameter int unsigned mcl_width_p       = 128,
  parameter int unsigned max_out_credits_p = 4,
  parameter int unsigned op_msb_p          = mcl_width_p - 1,
  parameter int unsigned err_ctr_width_p   = 16
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic                                   host_v_i,
  input  logic [mcl_width_p-1:0]                 host_data_i,
  output logic                                   host_r_o,
  input  logic [$clog2(max_out_credits_p+1)-1:0] rcv_vacancy_i,

  output logic                                   link_v_o,
  output logic [mcl_width_p-1:0]                 link_data_o,
  input  logic                                   link_r_i,
  input  logic                                   link_credit_i,

  input  logic                                   resp_v_i,
  input  logic [mcl_width_p-1:0]                 resp_data_i,
  output logic                                   resp_r_o,

  output logic                                   host_resp_v_o,
  output logic [mcl_width_p-1:0]                 host_resp_data_o,
  input  logic                                   host_resp_r_i,

  output logic                                   idle_o,
  output logic [err_ctr_width_p-1:0]             drop_count_o,
  output logic                                   err_o
);

  localparam int unsigned CredW = $clog2(max_out_credits_p + 1);
  localparam logic [CredW-1:0] CredMax = CredW'(max_out_credits_p);

  logic [CredW-1:0]           credits_q;
  logic [CredW-1:0]           pending_q;
  logic [err_ctr_width_p-1:0] drop_q;
  logic                       err_q;
  logic                       idle_q;

  // ---------------------------------------------------------------------------
  // Request decode and admission
  // ---------------------------------------------------------------------------
  logic [McOpWidth-1:0] op;
  logic                 is_load;
  logic                 is_legal;
  logic                 req_buf_r;
  logic                 credit_ok;
  logic                 vacancy_ok;
  logic                 accept;
  logic                 legal_accept;
  logic                 load_accept;
  logic                 drop_accept;

  assign op       = host_data_i[op_msb_p -: McOpWidth];
  assign is_load  = (op == e_mcl_op_load);
  assign is_legal = (op == e_mcl_op_store) | is_load;

  // A credit returned this cycle may be spent by a request accepted this cycle.
  assign credit_ok  = (credits_q != '0) | link_credit_i;
  // Each outstanding load owns one receive-FIFO slot for its reply.
  assign vacancy_ok = ~is_load | (pending_q < rcv_vacancy_i);

  // Illegal packets are swallowed unconditionally so they never block the stream.
  always_comb begin
    host_r_o = 1'b0;
    if (!reset_i) begin
      host_r_o = ~is_legal | (req_buf_r & credit_ok & vacancy_ok);
    end
  end

  assign accept       = host_v_i & host_r_o;
  assign legal_accept = accept & is_legal;
  assign load_accept  = accept & is_load;
  assign drop_accept  = accept & ~is_legal;

  // ---------------------------------------------------------------------------
  // Request and response pipe registers
  // ---------------------------------------------------------------------------
  mcl_pipe_reg #(
    .width_p (mcl_width_p)
  ) u_req_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (legal_accept),
    .data_i  (host_data_i),
    .r_o     (req_buf_r),
    .v_o     (link_v_o),
    .data_o  (link_data_o),
    .r_i     (link_r_i)
  );

  mcl_pipe_reg #(
    .width_p (mcl_width_p)
  ) u_resp_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (resp_v_i),
    .data_i  (resp_data_i),
    .r_o     (resp_r_o),
    .v_o     (host_resp_v_o),
    .data_o  (host_resp_data_o),
    .r_i     (host_resp_r_i)
  );

  logic resp_deliver;
  assign resp_deliver = host_resp_v_o & host_resp_r_i;

  // ---------------------------------------------------------------------------
  // Credit counter: spent at accept time so the buffer never holds an
  // uncredited packet; a return with all credits home saturates and flags.
  // ---------------------------------------------------------------------------
  logic             credit_err;
  logic [CredW-1:0] credits_d;

  assign credit_err = link_credit_i & (credits_q == CredMax);

  always_comb begin
    credits_d = credits_q;
    unique case ({legal_accept, link_credit_i})
      2'b10:   credits_d = credits_q - CredW'(1);
      2'b01:   credits_d = credit_err ? credits_q : credits_q + CredW'(1);
      default: credits_d = credits_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending-load counter: a reply with nothing pending is still forwarded but
  // flags an error and leaves the count at zero.
  // ---------------------------------------------------------------------------
  logic             resp_err;
  logic [CredW-1:0] pending_d;

  assign resp_err = resp_deliver & (pending_q == '0);

  always_comb begin
    pending_d = pending_q;
    unique case ({load_accept, resp_deliver})
      2'b10:   pending_d = pending_q + CredW'(1);
      2'b01:   pending_d = resp_err ? pending_q : pending_q - CredW'(1);
      default: pending_d = pending_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Drop counter, sticky error and idle flag
  // ---------------------------------------------------------------------------
  logic [err_ctr_width_p-1:0] drop_d;
  logic                       idle_d;

  always_comb begin
    drop_d = drop_q;
    if (drop_accept && (drop_q != '1)) begin
      drop_d = drop_q + err_ctr_width_p'(1);
    end
  end

  assign idle_d = (credits_q == CredMax) & (pending_q == '0) & ~link_v_o & ~host_resp_v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_q <= CredMax;
      pending_q <= '0;
      drop_q    <= '0;
      err_q     <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      credits_q <= credits_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      err_q     <= err_q | credit_err | resp_err;
      idle_q    <= idle_d;
    end
  end

  assign drop_count_o = drop_q;
  assign err_o        = err_q;
  assign idle_o       = idle_q;

endmodule

// File: tb/tb_mcl_host_req_gate.sv
module tb_mcl_host_req_gate;

  localparam int unsigned W    = 32;
  localparam int unsigned MAX  = 4;
  localparam int unsigned ERRW = 3;
  localparam int unsigned CW   = 3;
  localparam int          DROP_SAT = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_v;
  logic [W-1:0]  host_data;
  logic          host_r;
  logic [CW-1:0] vac;
  logic          link_v;
  logic [W-1:0]  link_data;
  logic          link_r;
  logic          link_credit;
  logic          resp_v;
  logic [W-1:0]  resp_data;
  logic          resp_r;
  logic          hr_v;
  logic [W-1:0]  hr_data;
  logic          hr_r;
  logic          idle;
  logic [ERRW-1:0] drop;
  logic          err;

  always #5 clk = ~clk;

  mcl_host_req_gate #(
    .mcl_width_p       (W),
    .max_out_credits_p (MAX),
    .err_ctr_width_p   (ERRW)
  ) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .host_v_i         (host_v),
    .host_data_i      (host_data),
    .host_r_o         (host_r),
    .rcv_vacancy_i    (vac),
    .link_v_o         (link_v),
    .link_data_o      (link_data),
    .link_r_i         (link_r),
    .link_credit_i    (link_credit),
    .resp_v_i         (resp_v),
    .resp_data_i      (resp_data),
    .resp_r_o         (resp_r),
    .host_resp_v_o    (hr_v),
    .host_resp_data_o (hr_data),
    .host_resp_r_i    (hr_r),
    .idle_o           (idle),
    .drop_count_o     (drop),
    .err_o            (err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: counts and FIFOs straight from the rules.
  int           m_credits;
  int           m_pending;
  int           m_drop;
  bit           m_err;
  bit           m_idle;
  logic [W-1:0] m_req[$];
  logic [W-1:0] m_resp[$];

  bit           e_host_r, e_link_v, e_resp_r, e_hr_v;
  logic [W-1:0] e_link_data, e_hr_data;

  function automatic logic [7:0] op_of(input logic [W-1:0] d);
    return d[W-1 -: 8];
  endfunction

  function automatic logic [W-1:0] pkt(input logic [7:0] op, input int tag);
    return {op, 24'(tag)};
  endfunction

  task automatic model_reset();
    m_credits = MAX; m_pending = 0; m_drop = 0; m_err = 0; m_idle = 1;
    m_req.delete(); m_resp.delete();
  endtask

  task automatic model_eval();
    logic [7:0] op;
    op          = op_of(host_data);
    e_link_v    = (m_req.size() != 0);
    e_link_data = e_link_v ? m_req[0] : '0;
    e_hr_v      = (m_resp.size() != 0);
    e_hr_data   = e_hr_v ? m_resp[0] : '0;
    e_resp_r    = !e_hr_v || hr_r;
    if (op > 8'h01) e_host_r = 1;
    else e_host_r = (!e_link_v || link_r) && (m_credits > 0 || link_credit) &&
                    (op != 8'h01 || m_pending < int'(vac));
  endtask

  task automatic model_update();
    logic [7:0] op;
    bit acc, legal, deliver, idle_next;
    op        = op_of(host_data);
    acc       = host_v && e_host_r;
    legal     = (op <= 8'h01);
    deliver   = e_hr_v && hr_r;
    idle_next = (m_credits == MAX) && (m_pending == 0) && (m_req.size() == 0) &&
                (m_resp.size() == 0);
    if (e_link_v && link_r) void'(m_req.pop_front());
    if (acc && legal) m_req.push_back(host_data);
    if (link_credit && m_credits == MAX) m_err = 1;
    m_credits = m_credits - int'(acc && legal) + int'(link_credit);
    if (m_credits > MAX) m_credits = MAX;
    if (deliver && m_pending == 0) m_err = 1;
    m_pending = m_pending + int'(acc && op == 8'h01) - int'(deliver);
    if (m_pending < 0) m_pending = 0;
    if (deliver) void'(m_resp.pop_front());
    if (resp_v && e_resp_r) m_resp.push_back(resp_data);
    if (acc && !legal && m_drop < DROP_SAT) m_drop++;
    m_idle = idle_next;
  endtask

  task automatic settle(); @(negedge clk); model_eval(); endtask
  task automatic tick();   model_update(); @(posedge clk); #1; endtask

  task automatic quiet_inputs();
    host_v = 0; host_data = '0; link_credit = 0; resp_v = 0; resp_data = '0;
    link_r = 1; hr_r = 1; vac = CW'(MAX);
  endtask

  // Returns outstanding credits and replies until everything is home.
  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      quiet_inputs();
      link_credit = (m_credits < MAX) && (m_req.size() == 0);
      resp_v      = (m_pending > m_resp.size());
      resp_data   = W'($urandom);
      settle(); tick();
      done = (m_credits == MAX) && (m_pending == 0) && (m_req.size() == 0) &&
             (m_resp.size() == 0) && m_idle;
    end
    quiet_inputs();
    n_cmp++;
    if (!done) begin n_fail++; $display("FAIL drain_timeout: got busy expected idle"); end
  endtask

  task automatic test_reset();
    quiet_inputs(); rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 6;
    if (link_v !== 1'b0) begin n_fail++; $display("FAIL rst_link_v: got %b expected 0", link_v); end
    if (host_r !== 1'b0) begin n_fail++; $display("FAIL rst_host_r: got %b expected 0", host_r); end
    if (hr_v !== 1'b0) begin n_fail++; $display("FAIL rst_hr_v: got %b expected 0", hr_v); end
    if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b expected 1", idle); end
    if (drop !== '0) begin n_fail++; $display("FAIL rst_drop: got %0d expected 0", drop); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
    @(posedge clk); #1 rst = 0;
    model_reset();
  endtask

  task automatic test_store_stream();
    int sent = 0;
    quiet_inputs();
    for (int c = 0; c < 8; c++) begin
      host_v = 1; host_data = pkt(8'h00, 16 + sent);
      settle();
      n_cmp += 3;
      if (host_r !== e_host_r || host_r !== (sent < MAX)) begin
        n_fail++; $display("FAIL store_host_r c%0d: got %b expected %b", c, host_r, sent < MAX);
      end
      if (link_v !== e_link_v) begin
        n_fail++; $display("FAIL store_link_v c%0d: got %b expected %b", c, link_v, e_link_v);
      end
      if (e_link_v && link_data !== e_link_data) begin
        n_fail++; $display("FAIL store_link_data c%0d: got %h expected %h", c, link_data,
                           e_link_data);
      end
      if (e_host_r) sent++;
      tick();
    end
    // A returned credit is usable in the same cycle; the packet issues next cycle.
    link_credit = 1; host_data = pkt(8'h00, 99);
    settle();
    n_cmp++;
    if (host_r !== 1'b1) begin n_fail++; $display("FAIL store_credit_ret: got %b expected 1", host_r); end
    tick();
    link_credit = 0; host_v = 0;
    settle();
    n_cmp++;
    if (link_v !== 1'b1 || link_data !== pkt(8'h00, 99)) begin
      n_fail++; $display("FAIL store_after_credit: got %b/%h expected 1/%h", link_v, link_data,
                         pkt(8'h00, 99));
    end
    tick();
    drain();
  endtask

  task automatic test_load_vacancy();
    int acc_cnt = 0;
    bit got_c = 0;
    quiet_inputs(); vac = 2;
    for (int c = 0; c < 5; c++) begin
      host_v = 1; host_data = pkt(8'h01, 40 + acc_cnt);
      settle();
      n_cmp++;
      if (host_r !== e_host_r || host_r !== (acc_cnt < 2)) begin
        n_fail++; $display("FAIL load_gate c%0d: got %b expected %b", c, host_r, acc_cnt < 2);
      end
      if (e_host_r) acc_cnt++;
      tick();
    end
    // Reply for the first load; the blocked third load then proceeds.
    resp_v = 1; resp_data = 32'hA5A5_0001;
    settle(); tick();
    resp_v = 0;
    for (int c = 0; c < 6 && !got_c; c++) begin
      settle();
      n_cmp++;
      if (host_r !== e_host_r) begin
        n_fail++; $display("FAIL load_unblock c%0d: got %b expected %b", c, host_r, e_host_r);
      end
      if (e_hr_v) begin
        n_cmp++;
        if (hr_data !== 32'hA5A5_0001) begin
          n_fail++; $display("FAIL load_reply_data: got %h expected a5a50001", hr_data);
        end
      end
      got_c = e_host_r;
      tick();
    end
    n_cmp++;
    if (!got_c) begin n_fail++; $display("FAIL load_third_accept: got 0 expected 1"); end
    host_data = pkt(8'h00, 77);
    settle();
    n_cmp++;
    if (host_r !== e_host_r) begin
      n_fail++; $display("FAIL load_store_behind: got %b expected %b", host_r, e_host_r);
    end
    tick();
    drain();
  endtask

  task automatic test_illegal();
    quiet_inputs();
    host_v = 1; host_data = pkt(8'h7F, 5);
    settle();
    n_cmp++;
    if (host_r !== 1'b1) begin n_fail++; $display("FAIL ill_accept: got %b expected 1", host_r); end
    tick();
    host_v = 0;
    settle();
    n_cmp += 2;
    if (link_v !== 1'b0) begin n_fail++; $display("FAIL ill_no_fwd: got %b expected 0", link_v); end
    if (drop !== ERRW'(1)) begin n_fail++; $display("FAIL ill_drop1: got %0d expected 1", drop); end
    tick();
    // Illegal packet still accepted when the buffer is full and stalled.
    link_r = 0; host_v = 1; host_data = pkt(8'h00, 6);
    settle(); tick();
    host_data = pkt(8'h7F, 7);
    settle();
    n_cmp++;
    if (host_r !== 1'b1) begin n_fail++; $display("FAIL ill_full_accept: got %b expected 1", host_r); end
    tick();
    link_r = 1;
    for (int c = 0; c < 8; c++) begin
      host_data = pkt(8'($urandom_range(2, 255)), c);
      settle();
      n_cmp += 2;
      if (host_r !== 1'b1) begin n_fail++; $display("FAIL ill_loop c%0d: got %b expected 1", c, host_r); end
      if (drop !== ERRW'(m_drop)) begin
        n_fail++; $display("FAIL ill_drop c%0d: got %0d expected %0d", c, drop, m_drop);
      end
      tick();
    end
    host_v = 0;
    settle();
    n_cmp++;
    if (drop !== ERRW'(DROP_SAT)) begin n_fail++; $display("FAIL ill_sat: got %0d expected 7", drop); end
    tick();
    drain();
  endtask

  task automatic test_stall();
    int acc_cnt = 0;
    quiet_inputs();
    link_r = 0; host_v = 1; host_data = pkt(8'h00, 300);
    settle(); tick();
    host_data = pkt(8'h00, 301);
    for (int c = 0; c < 10; c++) begin
      settle();
      n_cmp += 2;
      if (link_v !== 1'b1 || link_data !== pkt(8'h00, 300)) begin
        n_fail++; $display("FAIL stall_hold c%0d: got %b/%h expected 1/%h", c, link_v, link_data,
                           pkt(8'h00, 300));
      end
      if (host_r !== 1'b0) begin n_fail++; $display("FAIL stall_host_r c%0d: got %b expected 0", c, host_r); end
      tick();
    end
    // Only one credit went out during the stall: three more fit.
    link_r = 1;
    for (int c = 0; c < 8; c++) begin
      host_data = pkt(8'h00, 302 + acc_cnt);
      settle();
      if (e_host_r) acc_cnt++;
      tick();
    end
    n_cmp++;
    if (acc_cnt != MAX - 1) begin
      n_fail++; $display("FAIL stall_credits: got %0d accepted expected %0d", acc_cnt, MAX - 1);
    end
    drain();
  endtask

  task automatic test_credit_edge();
    int acc_cnt = 0;
    quiet_inputs();
    settle();
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL edge_err_pre: got %b expected 0", err); end
    tick();
    host_v = 1; host_data = pkt(8'h00, 500);
    settle(); tick();
    // Accept and credit return together: count stays at MAX-1.
    host_data = pkt(8'h00, 501); link_credit = 1;
    settle(); tick();
    link_credit = 0;
    for (int c = 0; c < 8; c++) begin
      host_data = pkt(8'h00, 502 + acc_cnt);
      settle();
      if (e_host_r) acc_cnt++;
      tick();
    end
    n_cmp++;
    if (acc_cnt != MAX - 1) begin
      n_fail++; $display("FAIL edge_same_cycle: got %0d accepted expected %0d", acc_cnt, MAX - 1);
    end
    drain();
    link_credit = 1;
    settle(); tick();
    link_credit = 0;
    settle();
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL edge_err_set: got %b expected 1", err); end
    tick(); settle();
    n_cmp += 2;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL edge_idle_max: got %b expected 1", idle); end
    if (err !== 1'b1) begin n_fail++; $display("FAIL edge_err_sticky: got %b expected 1", err); end
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 9));
      host_v    = ($urandom_range(0, 1) == 1);
      host_data = (r < 4) ? pkt(8'h00, c) : (r < 8) ? pkt(8'h01, c) :
                  pkt(8'($urandom_range(2, 255)), c);
      vac       = CW'($urandom_range(0, MAX));
      link_r    = ($urandom_range(0, 3) != 0);
      link_credit = ((m_credits + m_req.size() < MAX) && $urandom_range(0, 2) == 0) ||
                    ($urandom_range(0, 49) == 0);
      resp_v    = ($urandom_range(0, 2) == 0);
      resp_data = W'($urandom);
      hr_r      = ($urandom_range(0, 3) != 0);
      settle();
      n_cmp += 9;
      if (host_r !== e_host_r) begin n_fail++; $display("FAIL rnd_host_r c%0d: got %b expected %b", c, host_r, e_host_r); end
      if (link_v !== e_link_v) begin n_fail++; $display("FAIL rnd_link_v c%0d: got %b expected %b", c, link_v, e_link_v); end
      if (e_link_v && link_data !== e_link_data) begin
        n_fail++; $display("FAIL rnd_link_data c%0d: got %h expected %h", c, link_data, e_link_data);
      end
      if (resp_r !== e_resp_r) begin n_fail++; $display("FAIL rnd_resp_r c%0d: got %b expected %b", c, resp_r, e_resp_r); end
      if (hr_v !== e_hr_v) begin n_fail++; $display("FAIL rnd_hr_v c%0d: got %b expected %b", c, hr_v, e_hr_v); end
      if (e_hr_v && hr_data !== e_hr_data) begin
        n_fail++; $display("FAIL rnd_hr_data c%0d: got %h expected %h", c, hr_data, e_hr_data);
      end
      if (idle !== m_idle) begin n_fail++; $display("FAIL rnd_idle c%0d: got %b expected %b", c, idle, m_idle); end
      if (drop !== ERRW'(m_drop)) begin n_fail++; $display("FAIL rnd_drop c%0d: got %0d expected %0d", c, drop, m_drop); end
      if (err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b expected %b", c, err, m_err); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    quiet_inputs();
    link_r = 0; host_v = 1; host_data = pkt(8'h00, 900);
    settle(); tick();
    resp_v = 1; resp_data = 32'hDEAD_0001; hr_r = 0;
    settle(); tick();
    resp_v = 0;
    @(negedge clk);
    n_cmp++;
    if (link_v !== 1'b1 || hr_v !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got %b%b expected 11", link_v, hr_v);
    end
    #2 rst = 1;
    #1;
    n_cmp += 3;
    if (link_v !== 1'b0) begin n_fail++; $display("FAIL mid_link_v: got %b expected 0", link_v); end
    if (hr_v !== 1'b0) begin n_fail++; $display("FAIL mid_hr_v: got %b expected 0", hr_v); end
    if (host_r !== 1'b0) begin n_fail++; $display("FAIL mid_host_r: got %b expected 0", host_r); end
    @(posedge clk); @(posedge clk); #1 rst = 0;
    model_reset();
    quiet_inputs();
    settle();
    n_cmp++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle0: got %b expected 1", idle); end
    tick(); settle();
    n_cmp++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle1: got %b expected 1", idle); end
    tick();
  endtask

  initial begin
    quiet_inputs();
    model_reset();
    test_reset();
    test_store_stream();
    test_load_vacancy();
    test_illegal();
    test_stall();
    test_credit_edge();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
